wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Write-back stage: sits between the EX/MEM pipeline register and the register file write port.
//  Latches retiring instructions and waits for data-memory load responses.
//  Aligns and extends load data, then issues one register-file write per instruction on
//  REG_write_1 / REG_address_wr / REG_data_wb_in1.
//  Stalls upstream while a load is outstanding; flags misaligned loads and memory timeouts.
// PARAMETERS
//  TIMEOUT  16  max cycles in WAIT_LOAD before abandoning the load (>=2)
//  CNT_W    16  width of retired-instruction counter
// PORTS
//  clk              in   1      clock; all state updates on posedge (register file writes on negedge)
//  SYS_reset        in   1      asynchronous, active-high reset
//  MEM_valid        in   1      instruction present from EX/MEM
//  MEM_reg_write    in   1      instruction writes rd
//  MEM_mem_read     in   1      instruction is a load
//  MEM_load_type    in   3      000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal, treated as LW
//  MEM_rd           in   5      destination register
//  MEM_alu_result   in   32     ALU result; [1:0] is the load byte offset
//  DMEM_rvalid      in   1      load data valid (1-cycle pulse)
//  DMEM_rdata       in   32     raw aligned word from data memory
//  WB_stall         out  1      upstream must hold MEM_* stable
//  REG_write_1      out  1      register file write enable
//  REG_address_wr   out  5      register file write address
//  REG_data_wb_in1  out  32     register file write data
//  WB_misaligned    out  1      1-cycle pulse: misaligned load dropped
//  WB_timeout       out  1      1-cycle pulse: load abandoned after TIMEOUT
//  WB_retire_cnt    out  CNT_W  count of retired instructions, wraps to 0
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, counters 0; aborts any pending load; no write issued.
//  - States:
//    - IDLE: on posedge with MEM_valid:
//      - non-load: next cycle REG_write_1 = MEM_reg_write && MEM_rd!=0; addr = MEM_rd;
//        data = MEM_alu_result. Latency 1.
//      - load, aligned: latch rd, reg_write, type, offset; go WAIT_LOAD; wait counter = 0.
//      - load, misaligned (LH/LHU with off[0]=1; LW with off!=0): no write,
//        WB_misaligned pulses next cycle, stay IDLE.
//  - WAIT_LOAD: WB_stall = 1 for the whole state, including the rvalid cycle;
//    MEM_valid is ignored.
//    - DMEM_rvalid: next cycle write aligned data (REG_write_1 gated by reg_write && rd!=0);
//      go IDLE.
//    - Otherwise the counter increments. At count == TIMEOUT-1 with no rvalid:
//      WB_timeout pulses next cycle, no write, go IDLE.
//    - rvalid and expiry on the same cycle: rvalid wins.
//  - WB_stall = 0 in IDLE. DMEM_rvalid in IDLE is ignored.
//  - Alignment:
//    - LB/LBU select byte off, sign/zero extend.
//    - LH/LHU select half off[1], sign/zero extend.
//    - LW passes the word.
//  - REG_write_1, WB_misaligned and WB_timeout are single-cycle, registered, mutually exclusive.
//    REG_address_wr / REG_data_wb_in1 hold their last value when the write enable is low.
//  - WB_retire_cnt increments once per accepted instruction on completion:
//    write, no-write non-load, misaligned, or timeout. Wraps 2^CNT_W-1 -> 0.
//  - Back-to-back non-loads retire one per cycle. Next instruction accepted on the cycle
//    after the load completes.
// STRUCTURE
//  - Package wb_pkg: load-type localparams (LT_LB..LT_LHU); state encoding (S_IDLE, S_WAIT_LOAD).
//  - Sub-module load_align: combinational (rdata, type, off) -> 32-bit result.
//    Instantiated once; unit-tested on its own.
//  - Top: state register, pending-load latch, timeout counter, output regs, retire counter.
// TESTING
//  1. ALU op rd=5, alu=0x1234_5678 -> next cycle REG_write_1=1, addr=5,
//     data=0x1234_5678; cnt=1.
//  2. LB off=3, rdata=0x80FF_FF7F delivered 2 cycles later ->
//     WB_stall high 3 cycles, then write data 0xFFFF_FF80.
//     Repeat as LHU off=2 -> 0x0000_80FF.
//  3. LW off=1 -> WB_misaligned pulse, no write, no stall, cnt increments.
//  4. LW with no rvalid -> WB_stall for TIMEOUT cycles, then WB_timeout pulse, IDLE,
//     no write. Repeat with rvalid on the last cycle -> write, no timeout.
//  5. Writes to rd=0 (ALU and load) -> REG_write_1 stays 0; counter still increments.
//  6. SYS_reset mid-WAIT_LOAD, then late rvalid -> outputs 0, rvalid ignored, cnt=0.
//     Also: counter wrap with CNT_W=2 after 4 retires -> 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Write-back stage shared definitions: load encodings, state encoding
// and the load alignment legality check.
package wb_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_WAIT_LOAD = 1'b1;

    // Unlisted encodings behave as LW, so they need word alignment.
    function automatic logic is_misaligned(
        input logic [2:0] lt,
        input logic [1:0] off
    );
        logic r;
        r = 1'b0;
        case (lt)
            LT_LB, LT_LBU: r = 1'b0;
            LT_LH, LT_LHU: r = off[0];
            default:       r = (off != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data aligner: picks the byte/half selected by the address offset
// and sign- or zero-extends it to 32 bits.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  type_i,
    input  logic [1:0]  off_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (type_i)
            LT_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result_o = {24'd0, byte_sel};
            LT_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires EX/MEM instructions, waits for load data,
// and drives one register file write per instruction.
module wb_stage
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             SYS_reset,
    input  logic             MEM_valid,
    input  logic             MEM_reg_write,
    input  logic             MEM_mem_read,
    input  logic [2:0]       MEM_load_type,
    input  logic [4:0]       MEM_rd,
    input  logic [31:0]      MEM_alu_result,
    input  logic             DMEM_rvalid,
    input  logic [31:0]      DMEM_rdata,
    output logic             WB_stall,
    output logic             REG_write_1,
    output logic [4:0]       REG_address_wr,
    output logic [31:0]      REG_data_wb_in1,
    output logic             WB_misaligned,
    output logic             WB_timeout,
    output logic [CNT_W-1:0] WB_retire_cnt
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [0:0]       state_q, state_d;
    logic [4:0]       rd_q, rd_d;
    logic             regw_q, regw_d;
    logic [2:0]       lt_q, lt_d;
    logic [1:0]       off_q, off_d;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic             we_q, we_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             mis_q, mis_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             retire;
    logic [31:0]      ld_data;

    load_align u_align (
        .rdata_i  (DMEM_rdata),
        .type_i   (lt_q),
        .off_i    (off_q),
        .result_o (ld_data)
    );

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        regw_d  = regw_q;
        lt_d    = lt_q;
        off_d   = off_q;
        wcnt_d  = wcnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        mis_d   = 1'b0;
        to_d    = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MEM_valid) begin
                    if (!MEM_mem_read) begin
                        we_d   = MEM_reg_write && (MEM_rd != 5'd0);
                        retire = 1'b1;
                        if (we_d) begin
                            addr_d = MEM_rd;
                            data_d = MEM_alu_result;
                        end
                    end else if (is_misaligned(MEM_load_type,
                                               MEM_alu_result[1:0])) begin
                        mis_d  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        rd_d    = MEM_rd;
                        regw_d  = MEM_reg_write;
                        lt_d    = MEM_load_type;
                        off_d   = MEM_alu_result[1:0];
                        wcnt_d  = '0;
                        state_d = S_WAIT_LOAD;
                    end
                end
            end
            default: begin
                // Data arriving on the expiry cycle still counts.
                if (DMEM_rvalid) begin
                    we_d    = regw_q && (rd_q != 5'd0);
                    retire  = 1'b1;
                    state_d = S_IDLE;
                    if (we_d) begin
                        addr_d = rd_q;
                        data_d = ld_data;
                    end
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
        endcase
        ret_d = ret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            regw_q  <= 1'b0;
            lt_q    <= '0;
            off_q   <= '0;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            regw_q  <= regw_d;
            lt_q    <= lt_d;
            off_q   <= off_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
            ret_q   <= ret_d;
        end
    end

    assign WB_stall        = (state_q == S_WAIT_LOAD);
    assign REG_write_1     = we_q;
    assign REG_address_wr  = addr_q;
    assign REG_data_wb_in1 = data_q;
    assign WB_misaligned   = mis_q;
    assign WB_timeout      = to_q;
    assign WB_retire_cnt   = ret_q;

endmodule
